tetris_cmd_sched: RTL
=====================

TETRIS_CMD_SCHED -- requirements
Module: tetris_cmd_sched

Interface
REQ-001 Parameter NCH, default 4, number of command source channels (1..8).
REQ-002 Parameter QDEPTH, default 8, FIFO depth in entries (power of 2, >= 2).
REQ-003 Parameter CMD_W, default 4, command code width.
REQ-004 Parameter GRAV_TICK, default 50_000_000, base gravity period in clk cycles.
REQ-005 Parameter LVL_W, default 3, level input width.
REQ-006 clk  in  1  sole clock; every flop on posedge clk.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 src_valid  in  NCH  per-channel one-cycle command strobe.
REQ-009 src_cmd  in  NCH*CMD_W  per-channel command code; channel i at bits [i*CMD_W +: CMD_W].
REQ-010 run  in  1  gravity enable; low = gravity counter held at 0.
REQ-011 level  in  LVL_W  speed level; gravity period = GRAV_TICK >> level.
REQ-012 flush  in  1  synchronous queue clear.
REQ-013 cmd_valid  out  1  head entry present.
REQ-014 cmd  out  CMD_W  head command; CMD_NONE when empty.
REQ-015 cmd_ready  in  1  consumer accepts head when cmd_valid && cmd_ready.
REQ-016 count  out  $clog2(QDEPTH)+1  current occupancy.
REQ-017 drop_cnt  out  8  saturating count of discarded commands.

Function
REQ-018 Arbitration: fixed priority, highest-numbered valid channel wins; lower channels that cycle are dropped, each incrementing drop_cnt.
REQ-019 src_cmd equal to CMD_NONE with src_valid high is ignored, not counted.
REQ-020 Gravity: counter increments while run; on reaching (GRAV_TICK >> level)-1 wraps to 0 and raises internal grav request for one cycle with code CMD_DOWN.
REQ-021 grav request has lowest priority, below channel 0; when beaten by a channel it is held pending and retried each cycle until enqueued or flush.
REQ-022 level change mid-count: if counter >= new period-1, fire on next cycle and wrap to 0.
REQ-023 FIFO: one push per cycle max, one pop per cycle max; push and pop same cycle leaves count unchanged, entry order preserved.
REQ-024 Full (count == QDEPTH) without pop in same cycle: push discarded, drop_cnt increments; full with pop: push accepted.
REQ-025 Empty: cmd_valid = 0, cmd = CMD_NONE; pop ignored.
REQ-026 Latency: command strobed in cycle N visible on cmd/cmd_valid at cycle N+1 when queue was empty (registered output, no bypass).
REQ-027 cmd and cmd_valid stable while cmd_valid && !cmd_ready.
REQ-028 flush: next cycle count = 0, cmd_valid = 0, pending grav cleared; push in flush cycle discarded without drop_cnt increment; gravity counter unaffected.
REQ-029 drop_cnt saturates at 255, never wraps.
REQ-030 Pointers are $clog2(QDEPTH) bits and wrap modulo QDEPTH.

Reset
REQ-031 reset_n low asynchronously forces: count 0, pointers 0, cmd_valid 0, cmd CMD_NONE, drop_cnt 0, gravity counter 0, pending grav 0.
REQ-032 Reset assertion mid-transfer discards all entries; no partial pop is reported.

Configuration
REQ-033 Macro TETRIS_CMD_COALESCE_EN: when defined, a CMD_DOWN push whose tail entry (most recent, still queued) is already CMD_DOWN is absorbed (not stored, no drop_cnt increment); when undefined every push is stored per REQ-023/024.

Structure
REQ-034 Command codes (CMD_NONE=0, CMD_LEFT, CMD_RIGHT, CMD_DOWN, CMD_ROTATE, CMD_ROTATE_REV, CMD_DROP, CMD_HOLD, CMD_BAR) and GRAV_TICK default belong in package enum_type alongside state_type.
REQ-035 FIFO storage/pointers as sub-module cmd_fifo (params DEPTH, W; push/pop/full/empty/count); arbitration, gravity, coalescing in top.

Verification
REQ-036 Reset, src_valid=4'b0101 cmds {ch2=ROTATE, ch0=LEFT} -> next cycle cmd=ROTATE, count=1, drop_cnt=1.
REQ-037 GRAV_TICK=16, level=2, run=1, cmd_ready=1 -> cmd_valid pulses CMD_DOWN every 4 cycles.
REQ-038 QDEPTH=4, cmd_ready=0, push 6 LEFT -> count=4, drop_cnt=2; then push+pop same cycle -> count stays 4, head order kept.
REQ-039 Channel 0 strobe coincides with grav fire -> channel 0 enqueued, DOWN enqueued next cycle.
REQ-040 With TETRIS_CMD_COALESCE_EN, cmd_ready=0, three DOWN pushes -> count=1, drop_cnt=0; without macro -> count=3.
REQ-041 Queue holds 3, flush with simultaneous push; then reset_n low mid-pop -> count=0, drop_cnt=0, cmd=CMD_NONE immediately.

Source files
------------

// File: rtl/enum_type.sv
// Shared command codes, gravity default and grav-pending state for tetris_cmd_sched.
package enum_type;

    localparam int GRAV_TICK_DEF = 50_000_000;

    typedef enum logic [3:0] {
        CMD_NONE       = 4'd0,
        CMD_LEFT       = 4'd1,
        CMD_RIGHT      = 4'd2,
        CMD_DOWN       = 4'd3,
        CMD_ROTATE     = 4'd4,
        CMD_ROTATE_REV = 4'd5,
        CMD_DROP       = 4'd6,
        CMD_HOLD       = 4'd7,
        CMD_BAR        = 4'd8
    } cmd_type;

    typedef enum logic {
        GRAV_IDLE = 1'b0,
        GRAV_PEND = 1'b1
    } state_type;

endpackage

// File: rtl/tetris_cmd_sched_if.sv
// Source strobes and consumer handshake of the command scheduler.
interface tetris_cmd_sched_if #(
    parameter int NCH   = 4,
    parameter int CMD_W = 4
);
    logic [NCH-1:0]       src_valid;
    logic [NCH*CMD_W-1:0] src_cmd;
    logic                 cmd_valid;
    logic [CMD_W-1:0]     cmd;
    logic                 cmd_ready;

    modport master (
        output src_valid, src_cmd, cmd_ready,
        input  cmd_valid, cmd
    );

    modport slave (
        input  src_valid, src_cmd, cmd_ready,
        output cmd_valid, cmd
    );
endinterface

// File: rtl/cmd_fifo.sv
// Command FIFO: power-of-2 depth, wrapping pointers, registered occupancy.
module cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [W-1:0]             tail,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] tptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign tptr    = wptr - PW'(1);
    assign head    = mem[rptr];
    assign tail    = mem[tptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= din;
    end

endmodule

// File: rtl/tetris_cmd_sched.sv
// Priority command scheduler with gravity ticker and output FIFO.
// Optional TETRIS_CMD_COALESCE_EN merges back-to-back queued DOWN commands.
module tetris_cmd_sched
    import enum_type::*;
#(
    parameter int NCH       = 4,
    parameter int QDEPTH    = 8,
    parameter int CMD_W     = 4,
    parameter int GRAV_TICK = GRAV_TICK_DEF,
    parameter int LVL_W     = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    tetris_cmd_sched_if.slave         bus,
    input  logic                      run,
    input  logic [LVL_W-1:0]          level,
    input  logic                      flush,
    output logic [$clog2(QDEPTH):0]   count,
    output logic [7:0]                drop_cnt
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int GW = $clog2(GRAV_TICK + 1);
    localparam logic [CMD_W-1:0] C_NONE = CMD_W'(CMD_NONE);
    localparam logic [CMD_W-1:0] C_DOWN = CMD_W'(CMD_DOWN);

    state_type        gstate;
    logic [GW-1:0]    gcnt;
    logic [GW-1:0]    period;
    logic             hit;
    logic             grav_req;
    logic             win;
    logic [CMD_W-1:0] win_cmd;
    logic [3:0]       nreq;
    logic [3:0]       losers;
    logic             push_req;
    logic [CMD_W-1:0] push_cmd;
    logic             pop;
    logic             absorb;
    logic             push;
    logic             full_drop;
    logic [4:0]       drops;
    logic [8:0]       dsum;
    logic [CMD_W-1:0] head;
    logic [CMD_W-1:0] tail;
    logic             full;
    logic             empty;

    // Period of 0 or 1 collapses to firing every cycle.
    assign period = GW'(GRAV_TICK) >> level;
    assign hit    = run &&
        (({1'b0, gcnt} + {{GW{1'b0}}, 1'b1}) >= {1'b0, period});

    always_comb begin
        win     = 1'b0;
        win_cmd = C_NONE;
        nreq    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.src_valid[i] &&
                bus.src_cmd[i*CMD_W +: CMD_W] != C_NONE) begin
                nreq    = nreq + 4'd1;
                win     = 1'b1;
                win_cmd = bus.src_cmd[i*CMD_W +: CMD_W];
            end
        end
    end

    assign losers   = nreq - {3'b000, win};
    assign grav_req = hit || (gstate == GRAV_PEND);
    assign push_req = win || grav_req;
    assign push_cmd = win ? win_cmd : C_DOWN;
    assign pop      = bus.cmd_valid && bus.cmd_ready;

`ifdef TETRIS_CMD_COALESCE_EN
    // A lone DOWN being popped this cycle is no longer queued.
    assign absorb = (push_cmd == C_DOWN) && !empty && (tail == C_DOWN)
                    && !(pop && count == CW'(1));
`else
    logic unused_tail;
    assign unused_tail = ^tail;
    assign absorb      = 1'b0;
`endif

    assign push      = push_req && !absorb && !flush && (!full || pop);
    assign full_drop = push_req && !absorb && !flush && full && !pop;
    assign drops     = {1'b0, losers} + {4'b0000, full_drop};
    assign dsum      = {1'b0, drop_cnt} + {4'b0000, drops};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gcnt     <= '0;
            gstate   <= GRAV_IDLE;
            drop_cnt <= '0;
        end else begin
            if (!run || hit) gcnt <= '0;
            else             gcnt <= gcnt + GW'(1);
            if (flush)                gstate <= GRAV_IDLE;
            else if (grav_req && win) gstate <= GRAV_PEND;
            else                      gstate <= GRAV_IDLE;
            drop_cnt <= dsum[8] ? 8'hFF : dsum[7:0];
        end
    end

    cmd_fifo #(
        .DEPTH (QDEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (push),
        .din     (push_cmd),
        .pop     (pop),
        .head    (head),
        .tail    (tail),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign bus.cmd_valid = !empty;
    assign bus.cmd       = empty ? C_NONE : head;

endmodule
